// File: rtl/irrigation_actuator_seq.sv
// -----------------------------------------------------------------------------
// irrigation_actuator_seq
//   Valve sequencer sitting behind the tank/irrigation decision logic. It turns
//   the upstream requests into physical valve drives while guaranteeing that
//   the sprinkler and drip valves are never open together. It also enforces a
//   minimum on-time and a cooldown for the irrigation valves, and it shuts
//   everything off on a sensor error. After an error the alarm blinks until
//   the error has stayed clear for a qualified time.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   asp_req      in   sprinkler request
//   got_req      in   drip request
//   supply_req   in   tank refill request
//   error        in   sensor inconsistency flag
//   asp_valve    out  sprinkler valve drive (registered)
//   got_valve    out  drip valve drive (registered)
//   supply_valve out  tank inlet valve drive (registered)
//   alarm        out  blinking fault indicator (registered)
//   state        out  current FSM state code
// -----------------------------------------------------------------------------
module irrigation_actuator_seq #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned MIN_ON   = 5,
  parameter int unsigned MIN_OFF  = 3,
  parameter int unsigned CLEAR_T  = 2,
  parameter int unsigned BLINK    = 1,
  parameter int unsigned TW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       asp_req,
  input  logic       got_req,
  input  logic       supply_req,
  input  logic       error,
  output logic       asp_valve,
  output logic       got_valve,
  output logic       supply_valve,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ASP   = 3'd1;
  localparam logic [2:0] S_GOT   = 3'd2;
  localparam logic [2:0] S_COOL  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [PW-1:0] PSC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_ZERO    = TW'(0);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] T_MIN_ON  = TW'(MIN_ON);
  localparam logic [TW-1:0] T_MIN_OFF = TW'(MIN_OFF);
  localparam logic [TW-1:0] T_CLEAR   = TW'(CLEAR_T);
  localparam logic [TW-1:0] T_BLINK   = TW'(BLINK);

  logic [2:0]    state_q,  state_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [TW-1:0] blink_q,  blink_d;
  logic [PW-1:0] psc_q,    psc_d;
  logic          alarm_q,  alarm_d;
  logic          asp_q,    got_q,   supply_q;

  logic          tick_s;
  logic          expire_s;
  logic          done_s;

  // Next-state, timer, prescaler and alarm computation.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    blink_d = blink_q;
    alarm_d = alarm_q;

    tick_s   = (psc_q == PSC_LAST);
    // expire_s: this edge takes the timer from 1 to 0.
    expire_s = tick_s && (timer_q == T_ONE);
    // done_s: the minimum interval has elapsed or elapses on this edge.
    done_s   = (timer_q == T_ZERO) || expire_s;

    if (tick_s) begin
      psc_d = {PW{1'b0}};
    end else begin
      psc_d = psc_q + PW'(1);
    end

    if (tick_s && (timer_q != T_ZERO)) begin
      timer_d = timer_q - T_ONE;
    end else begin
      timer_d = timer_q;
    end

    if (error) begin
      // Error dominates every state; while it is held the clearing interval
      // and the blink phase are kept at their start values.
      state_d = S_FAULT;
      timer_d = T_CLEAR;
      blink_d = T_BLINK;
      alarm_d = 1'b1;
      psc_d   = {PW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (asp_req) begin
            state_d = S_ASP;
            timer_d = T_MIN_ON;
          end else if (got_req) begin
            state_d = S_GOT;
            timer_d = T_MIN_ON;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ASP: begin
          if (!asp_req && done_s) begin
            state_d = S_COOL;
            timer_d = T_MIN_OFF;
          end else begin
            state_d = S_ASP;
          end
        end
        S_GOT: begin
          // The sprinkler pre-empts drip once the minimum on-time has elapsed.
          if ((!got_req || asp_req) && done_s) begin
            state_d = S_COOL;
            timer_d = T_MIN_OFF;
          end else begin
            state_d = S_GOT;
          end
        end
        S_COOL: begin
          if (done_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_COOL;
          end
        end
        S_FAULT: begin
          if (tick_s) begin
            if (blink_q <= T_ONE) begin
              alarm_d = ~alarm_q;
              blink_d = T_BLINK;
            end else begin
              blink_d = blink_q - T_ONE;
            end
          end else begin
            blink_d = blink_q;
          end
          if (done_s) begin
            state_d = S_COOL;
            timer_d = T_MIN_OFF;
            alarm_d = 1'b0;
          end else begin
            state_d = S_FAULT;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = T_ZERO;
          alarm_d = 1'b0;
        end
      endcase
    end

    // Restart the prescaler on every state change so intervals are whole ticks.
    if (state_d != state_q) begin
      psc_d = {PW{1'b0}};
    end else begin
      psc_d = psc_d;
    end
  end

  // State, timers and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= T_ZERO;
      blink_q  <= T_ZERO;
      psc_q    <= {PW{1'b0}};
      alarm_q  <= 1'b0;
      asp_q    <= 1'b0;
      got_q    <= 1'b0;
      supply_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      blink_q  <= blink_d;
      psc_q    <= psc_d;
      alarm_q  <= alarm_d;
      // Valve drives follow the state register exactly; decoding the next
      // state keeps them registered without adding a cycle of latency.
      asp_q    <= (state_d == S_ASP);
      got_q    <= (state_d == S_GOT);
      supply_q <= supply_req & ~error & (state_q != S_FAULT);
    end
  end

  assign asp_valve    = asp_q;
  assign got_valve    = got_q;
  assign supply_valve = supply_q;
  assign alarm        = alarm_q;
  assign state        = state_q;

endmodule

// File: tb/tb_irrigation_actuator_seq.sv
module tb_irrigation_actuator_seq;

  localparam int TD  = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int CLR = 2;
  localparam int BL  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       asp_req = 1'b0;
  logic       got_req = 1'b0;
  logic       supply_req = 1'b0;
  logic       error = 1'b0;
  logic       asp_valve, got_valve, supply_valve, alarm;
  logic [2:0] state;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed cycles in the current state / since error cleared
  int m_st = 0;
  int m_k = 0;
  int m_c = 0;
  logic m_sup = 1'b0;
  logic m_alarm = 1'b0;

  irrigation_actuator_seq #(
    .TICK_DIV(TD), .MIN_ON(ON), .MIN_OFF(OFF), .CLEAR_T(CLR), .BLINK(BL), .TW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .asp_req(asp_req), .got_req(got_req),
    .supply_req(supply_req), .error(error), .asp_valve(asp_valve),
    .got_valve(got_valve), .supply_valve(supply_valve), .alarm(alarm),
    .state(state)
  );

  assign obs = {state, asp_valve, got_valve, supply_valve, alarm};

  always #5 clk = ~clk;

  function automatic logic [6:0] model_vec();
    logic [2:0] s;
    s = 3'(m_st);
    return {s, (m_st == 1), (m_st == 2), m_sup, m_alarm};
  endfunction

  task automatic model_update(input logic a, g, s, e, r);
    if (!r) begin
      m_st = 0; m_k = 0; m_c = 0; m_sup = 1'b0; m_alarm = 1'b0;
    end else begin
      m_sup = s & ~e & (m_st != 4);
      if (e) begin
        m_st = 4; m_c = 0; m_alarm = 1'b1;
      end else begin
        case (m_st)
          0: if (a) begin m_st = 1; m_k = 0; end
             else if (g) begin m_st = 2; m_k = 0; end
          1: begin
               m_k++;
               if (m_k >= ON*TD && !a) begin m_st = 3; m_k = 0; end
             end
          2: begin
               m_k++;
               if (m_k >= ON*TD && (!g || a)) begin m_st = 3; m_k = 0; end
             end
          3: begin
               m_k++;
               if (m_k == OFF*TD) begin m_st = 0; m_k = 0; end
             end
          default: begin
               m_c++;
               if (m_c == CLR*TD) begin
                 m_st = 3; m_k = 0; m_alarm = 1'b0;
               end else begin
                 m_alarm = ((m_c / (BL*TD)) % 2) == 0;
               end
             end
        endcase
      end
    end
  endtask

  task automatic step(input logic a, g, s, e, r);
    asp_req = a; got_req = g; supply_req = s; error = e; rst_n = r;
    @(posedge clk);
    model_update(a, g, s, e, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== 7'd0) begin
        errors++;
        $display("FAIL reset_values: got %b expected %b", obs, 7'd0);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs, model_vec());
    end
  endtask

  task automatic test_asp_pulse();
    int n_on = 0;
    int n_cool = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (asp_valve !== 1'b1) begin
      errors++;
      $display("FAIL pulse_first_cycle: asp_valve %b expected 1", asp_valve);
    end
    if (asp_valve === 1'b1) n_on++;
    for (int i = 0; i < 29; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL pulse_seq cyc %0d: got %b expected %b", i, obs, model_vec());
      end
      if (asp_valve === 1'b1) n_on++;
      if (state === 3'd3) n_cool++;
    end
    checks++;
    if (n_on != 12 || n_cool != 8 || state !== 3'd0) begin
      errors++;
      $display("FAIL pulse_durations: on %0d cool %0d state %0d expected 12 8 0", n_on, n_cool, state);
    end
  endtask

  task automatic test_both();
    int n_got = 0;
    int n_cool = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL both_hold cyc %0d: got %b expected %b", i, obs, model_vec());
      end
      if (got_valve === 1'b1) n_got++;
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL both_release cyc %0d: got %b expected %b", i, obs, model_vec());
      end
      if (state === 3'd3) n_cool++;
    end
    checks++;
    if (n_got != 0 || n_cool != 8 || got_valve !== 1'b1) begin
      errors++;
      $display("FAIL both_priority: got_on %0d cool %0d got_valve %b expected 0 8 1", n_got, n_cool, got_valve);
    end
  endtask

  task automatic do_idle();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL idle_drain cyc %0d: got %b expected %b", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_preempt();
    int n_got = 0;
    int n_both = 0;
    for (int i = 0; i < 29; i++) begin
      step((i >= 4), 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL preempt cyc %0d: got %b expected %b", i, obs, model_vec());
      end
      if (got_valve === 1'b1) n_got++;
      if (got_valve === 1'b1 && asp_valve === 1'b1) n_both++;
    end
    checks++;
    if (n_got != 12 || n_both != 0 || asp_valve !== 1'b1) begin
      errors++;
      $display("FAIL preempt_timing: got_on %0d both %0d asp %b expected 12 0 1", n_got, n_both, asp_valve);
    end
  endtask

  task automatic test_error_asp();
    int n_fault = 1;
    int n_cool = 0;
    logic al3 = 1'b0;
    logic al4 = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({state, asp_valve, supply_valve, alarm} !== {3'd4, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL error_entry: state %0d asp %b sup %b alarm %b expected 4 0 0 1", state, asp_valve, supply_valve, alarm);
    end
    for (int j = 1; j <= 20; j++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL error_clear cyc %0d: got %b expected %b", j, obs, model_vec());
      end
      if (state === 3'd4) n_fault++;
      if (state === 3'd3) n_cool++;
      if (j == 3) al3 = alarm;
      if (j == 4) al4 = alarm;
    end
    checks++;
    if (n_fault != 8 || n_cool != 8 || al3 !== 1'b1 || al4 !== 1'b0) begin
      errors++;
      $display("FAIL error_timing: fault %0d cool %0d al3 %b al4 %b expected 8 8 1 0", n_fault, n_cool, al3, al4);
    end
  endtask

  task automatic test_error_reassert();
    int exit_j = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL reassert_clear cyc %0d: got %b expected %b", i, obs, model_vec());
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int j = 1; j <= 20; j++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (state !== 3'd4 && exit_j == 0) exit_j = j;
    end
    checks++;
    if (exit_j != 8) begin
      errors++;
      $display("FAIL reassert_exit: left FAULT after %0d cycles expected 8", exit_j);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid: got %b expected %b", obs, 7'd0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd1 || asp_valve !== 1'b1 || got_valve !== 1'b0) begin
      errors++;
      $display("FAIL reset_reentry: state %0d asp %b got %b expected 1 1 0", state, asp_valve, got_valve);
    end
  endtask

  task automatic test_random();
    logic a = 1'b0, g = 1'b0, s = 1'b0, e = 1'b0, r;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      if ($urandom_range(0, 7) == 0) g = ~g;
      if ($urandom_range(0, 5) == 0) s = ~s;
      if (e) e = ($urandom_range(0, 2) != 0);
      else   e = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 299) != 0);
      step(a, g, s, e, r);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b expected %b", i, obs, model_vec());
      end
      checks++;
      if (asp_valve === 1'b1 && got_valve === 1'b1) begin
        errors++;
        $display("FAIL random_exclusive cyc %0d: asp %b got %b expected not both", i, asp_valve, got_valve);
      end
    end
  endtask

  initial begin
    test_reset();
    test_asp_pulse();
    test_both();
    do_idle();
    test_preempt();
    do_idle();
    test_error_asp();
    test_error_reassert();
    do_idle();
    test_reset_mid();
    do_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irrigation_actuator_seq.md
Name: irrigation_actuator_seq

Overview:
- Downstream stage of the tank/irrigation controller. Consumes its combinational decisions (asp, got, watter_supply, error) and drives the physical valves.
- Guarantees sprinkler and drip are never on together and enforces minimum on/off times.
- Forces all valves off on sensor error and blinks the alarm until the error has been clear for a qualified time.

Parameters:
- TICK_DIV, 1000: clk cycles per timing tick (at least 2).
- MIN_ON, 5: minimum irrigation valve on-time, in ticks (at least 1).
- MIN_OFF, 3: cooldown between irrigation valve changes, in ticks (at least 1).
- CLEAR_T, 2: ticks error must stay low before leaving FAULT (at least 1).
- BLINK, 1: ticks per alarm toggle in FAULT (at least 1).
- TW, 8: timer width; all tick parameters must be below 2^TW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- asp_req  in  1  sprinkler request from upstream asp.
- got_req  in  1  drip request from upstream got.
- supply_req  in  1  tank refill request from upstream watter_supply.
- error  in  1  sensor inconsistency flag from upstream.
- asp_valve  out  1  sprinkler valve drive.
- got_valve  out  1  drip valve drive.
- supply_valve  out  1  tank inlet valve drive.
- alarm  out  1  blinking fault indicator.
- state  out  3  current FSM state code.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: when rst_n=0 at a rising clk edge, the block resets.
- Reset values:
  - state=IDLE(0), timer=0, prescaler=0.
  - asp_valve=0, got_valve=0, supply_valve=0, alarm=0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick=1 in the cycle where prescaler==TICK_DIV-1.
  - Cleared to 0 on every state transition, so timed intervals are exact multiples of TICK_DIV cycles.
- Timer:
  - Loaded on state entry.
  - On each tick, decrements when nonzero.
- States: IDLE=0, ASP=1, GOT=2, COOL=3, FAULT=4.
- Priority 1: error=1 in any state moves to FAULT at the next edge. Timer is loaded with CLEAR_T and alarm is set to 1.
- IDLE:
  - asp_req=1 -> ASP, timer=MIN_ON.
  - else got_req=1 -> GOT, timer=MIN_ON.
  - Both requests high: ASP wins.
- ASP:
  - Exit condition is asp_req=0. got_req is ignored.
  - Leaves to COOL (timer=MIN_OFF) on the edge where timer decrements from 1 to 0, if the exit condition is true.
  - After that, leaves on the first edge where the exit condition is true.
- GOT:
  - Exit condition is got_req=0 OR asp_req=1 (sprinkler pre-empts after min on).
  - Same timing rule as ASP; leaves to COOL.
- COOL: goes to IDLE on the edge where timer reaches 0. Requests are ignored.
- FAULT:
  - While error=1, timer reloads CLEAR_T and prescaler is held at 0.
  - Once error=0, the timer counts ticks. At 0, goes to COOL (timer=MIN_OFF) and alarm=0.
  - If error reasserts mid-count, the timer reloads.
- Valve outputs (decoded from the state register, so request to valve is 1 cycle):
  - asp_valve=(state==ASP).
  - got_valve=(state==GOT).
  - Never both 1.
- supply_valve:
  - Registered: next value = supply_req & ~error & (state!=FAULT).
  - 1-cycle latency; drops the cycle after error rises.
  - Independent of the irrigation FSM otherwise.
- alarm:
  - 0 outside FAULT.
  - In FAULT, toggles every BLINK ticks. While error=1 the prescaler is held, so alarm stays 1 until error clears, then blinks during the clearing interval.
- Minimum durations: a single-cycle request still gives exactly MIN_ON*TICK_DIV cycles of valve on, followed by MIN_OFF*TICK_DIV cycles of cooldown.
- Reset asserted mid-operation: all valves drop on the reset edge; no cooldown is enforced after reset.

Test Plan:
- Setup: TICK_DIV=4, MIN_ON=3, MIN_OFF=2, CLEAR_T=2, BLINK=1.
- 1-cycle asp_req pulse from IDLE -> asp_valve=1 for exactly 12 cycles starting 1 cycle after the pulse; state=3 for 8 cycles; then state=0.
- asp_req and got_req both held high -> asp_valve only, got_valve=0 throughout; drop asp_req after 20 cycles -> COOL for 8 cycles, then GOT entered and got_valve=1.
- got active 4 cycles, then asp_req rises -> got_valve stays 1 until 12 cycles total, then 8 cycles COOL, then asp_valve=1; never both high.
- error pulse while in ASP:
  - Next edge: asp_valve=0, supply_valve=0, state=4, alarm=1.
  - After error falls: alarm toggles every 4 cycles, FAULT lasts 8 cycles, then COOL 8 cycles.
- error reasserted after 5 cycles of clearing -> timer reloads; FAULT exit occurs 8 cycles after the final error fall.
- rst_n=0 for 1 cycle mid-ASP with requests held -> all outputs 0 and state=0 after the edge; ASP re-entered on the following edge.
